// File: rtl/hazard_stall_controller_if.sv
// Pipeline-side bundle for the hazard/stall controller: hazard sources in,
// stage enables, flushes, freeze and performance counters out.
interface hazard_stall_controller_if #(parameter int CNT_W = 32);
  logic             MemRead_EX_i;
  logic [4:0]       Write_Register_EX_i;
  logic [4:0]       Read_Register_1_ID_i;
  logic [4:0]       Read_Register_2_ID_i;
  logic             Branch_Taken_ID_i;
  logic             Mem_Req_MEM_i;
  logic             Dcache_Ack_i;
  logic             PC_Write_o;
  logic             IF_ID_Write_o;
  logic             IF_ID_Flush_o;
  logic             ID_EX_Flush_o;
  logic             Freeze_o;
  logic [CNT_W-1:0] Stall_Count_o;
  logic [CNT_W-1:0] Miss_Count_o;
  logic             Protocol_Err_o;

  // pipeline / datapath side
  modport master (
    output MemRead_EX_i, Write_Register_EX_i, Read_Register_1_ID_i,
           Read_Register_2_ID_i, Branch_Taken_ID_i, Mem_Req_MEM_i, Dcache_Ack_i,
    input  PC_Write_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_Flush_o, Freeze_o,
           Stall_Count_o, Miss_Count_o, Protocol_Err_o
  );

  // controller side
  modport slave (
    input  MemRead_EX_i, Write_Register_EX_i, Read_Register_1_ID_i,
           Read_Register_2_ID_i, Branch_Taken_ID_i, Mem_Req_MEM_i, Dcache_Ack_i,
    output PC_Write_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_Flush_o, Freeze_o,
           Stall_Count_o, Miss_Count_o, Protocol_Err_o
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller: dcache-miss freeze, load-use bubble,
// taken-branch IF/ID flush, plus saturating stall/miss counters.
module hazard_stall_controller #(
  parameter int CNT_W = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  hazard_stall_controller_if.slave  bus
);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;

  logic [0:0]       state, state_nxt;
  logic             miss, load_use;
  logic [CNT_W-1:0] stall_cnt, miss_cnt;
  logic             perr;

  assign miss     = bus.Mem_Req_MEM_i & ~bus.Dcache_Ack_i;
  assign load_use = bus.MemRead_EX_i & (bus.Write_Register_EX_i != 5'd0) &
                    ((bus.Write_Register_EX_i == bus.Read_Register_1_ID_i) |
                     (bus.Write_Register_EX_i == bus.Read_Register_2_ID_i));

  // Stage control: reset holds everything, then freeze > load-use > branch.
  always_comb begin
    bus.Freeze_o      = 1'b0;
    bus.PC_Write_o    = 1'b1;
    bus.IF_ID_Write_o = 1'b1;
    bus.IF_ID_Flush_o = 1'b0;
    bus.ID_EX_Flush_o = 1'b0;
    if (rst_i) begin
      bus.Freeze_o      = 1'b1;
      bus.PC_Write_o    = 1'b0;
      bus.IF_ID_Write_o = 1'b0;
    end else if (miss) begin
      bus.Freeze_o      = 1'b1;
      bus.PC_Write_o    = 1'b0;
      bus.IF_ID_Write_o = 1'b0;
    end else if (load_use) begin
      // branch in this cycle is dropped; it re-resolves after the bubble
      bus.PC_Write_o    = 1'b0;
      bus.IF_ID_Write_o = 1'b0;
      bus.ID_EX_Flush_o = 1'b1;
    end else if (bus.Branch_Taken_ID_i) begin
      bus.IF_ID_Flush_o = 1'b1;
    end
  end

  // Wait tracking: enter on a miss from RUN, leave on ack or a dropped request.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      if (miss) state_nxt = MEM_WAIT;
      MEM_WAIT: if (!bus.Mem_Req_MEM_i || bus.Dcache_Ack_i) state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  // State, saturating counters and the sticky protocol error flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= RUN;
      stall_cnt <= '0;
      miss_cnt  <= '0;
      perr      <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((miss || load_use) && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if ((state == RUN) && miss && (miss_cnt != {CNT_W{1'b1}}))
        miss_cnt <= miss_cnt + CNT_W'(1);
      if ((state == MEM_WAIT) && !bus.Mem_Req_MEM_i)
        perr <= 1'b1;
    end
  end

  assign bus.Stall_Count_o  = stall_cnt;
  assign bus.Miss_Count_o   = miss_cnt;
  assign bus.Protocol_Err_o = perr;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench: the driver applies one vector per cycle and queues the
// hand-computed response; a monitor on the falling edge pops and compares.
module tb_hazard_stall_controller;

  // expected stage control bits: {Freeze, PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}
  localparam logic [4:0] ADV = 5'b01100;
  localparam logic [4:0] FRZ = 5'b10000;
  localparam logic [4:0] LU  = 5'b00001;
  localparam logic [4:0] BR  = 5'b01110;

  typedef struct {
    string       name;
    bit          sel;    // 0: main DUT (CNT_W=32), 1: saturation DUT (CNT_W=4)
    logic [4:0]  ctl;
    logic [31:0] stall;
    logic [31:0] miss;
    logic        perr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_m = 1'b1;
  logic rst_s = 1'b1;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  hazard_stall_controller_if #(.CNT_W(32)) m_if ();
  hazard_stall_controller_if #(.CNT_W(4))  s_if ();

  hazard_stall_controller #(.CNT_W(32)) dut_m (.clk_i(clk), .rst_i(rst_m), .bus(m_if.slave));
  hazard_stall_controller #(.CNT_W(4))  dut_s (.clk_i(clk), .rst_i(rst_s), .bus(s_if.slave));

  always #5 clk = ~clk;

  task automatic step(input string nm, input bit sel, input bit r, input bit rq, input bit ak,
                      input bit mr, input logic [4:0] wr, input logic [4:0] r1,
                      input logic [4:0] r2, input bit br, input logic [4:0] ctl,
                      input int s, input int m, input bit p);
    exp_t e;
    @(posedge clk);
    #1;
    if (!sel) begin
      rst_m = r;
      m_if.Mem_Req_MEM_i = rq;        m_if.Dcache_Ack_i = ak;
      m_if.MemRead_EX_i = mr;         m_if.Write_Register_EX_i = wr;
      m_if.Read_Register_1_ID_i = r1; m_if.Read_Register_2_ID_i = r2;
      m_if.Branch_Taken_ID_i = br;
    end else begin
      rst_s = r;
      s_if.Mem_Req_MEM_i = rq;        s_if.Dcache_Ack_i = ak;
      s_if.MemRead_EX_i = mr;         s_if.Write_Register_EX_i = wr;
      s_if.Read_Register_1_ID_i = r1; s_if.Read_Register_2_ID_i = r2;
      s_if.Branch_Taken_ID_i = br;
    end
    e.name = nm; e.sel = sel; e.ctl = ctl;
    e.stall = 32'(s); e.miss = 32'(m); e.perr = p;
    sb.push_back(e);
  endtask

  // Monitor: every falling edge with a pending expectation is one comparison.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t        e;
      logic [4:0]  ctl;
      logic [31:0] st, ms;
      logic        pe;
      e = sb.pop_front();
      if (!e.sel) begin
        ctl = {m_if.Freeze_o, m_if.PC_Write_o, m_if.IF_ID_Write_o, m_if.IF_ID_Flush_o, m_if.ID_EX_Flush_o};
        st = m_if.Stall_Count_o; ms = m_if.Miss_Count_o; pe = m_if.Protocol_Err_o;
      end else begin
        ctl = {s_if.Freeze_o, s_if.PC_Write_o, s_if.IF_ID_Write_o, s_if.IF_ID_Flush_o, s_if.ID_EX_Flush_o};
        st = 32'(s_if.Stall_Count_o); ms = 32'(s_if.Miss_Count_o); pe = s_if.Protocol_Err_o;
      end
      total++;
      if (ctl !== e.ctl || st !== e.stall || ms !== e.miss || pe !== e.perr) begin
        bad++;
        $display("FAIL %s: got ctl=%b stall=%0d miss=%0d perr=%b, want ctl=%b stall=%0d miss=%0d perr=%b",
                 e.name, ctl, st, ms, pe, e.ctl, e.stall, e.miss, e.perr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    m_if.Mem_Req_MEM_i = 0; m_if.Dcache_Ack_i = 0; m_if.MemRead_EX_i = 0;
    m_if.Write_Register_EX_i = 0; m_if.Read_Register_1_ID_i = 0;
    m_if.Read_Register_2_ID_i = 0; m_if.Branch_Taken_ID_i = 0;
    s_if.Mem_Req_MEM_i = 0; s_if.Dcache_Ack_i = 0; s_if.MemRead_EX_i = 0;
    s_if.Write_Register_EX_i = 0; s_if.Read_Register_1_ID_i = 0;
    s_if.Read_Register_2_ID_i = 0; s_if.Branch_Taken_ID_i = 0;

    //    name            sel rst req ack mr  wr  r1  r2 br  ctl  stall miss perr
    step("reset_hold",     0, 1,  0,  0,  0,  0,  0,  0, 0, FRZ,  0, 0, 0);
    step("idle",           0, 0,  0,  0,  0,  0,  0,  0, 0, ADV,  0, 0, 0);
    step("load_use_rt",    0, 0,  0,  0,  1,  5,  0,  5, 0, LU,   0, 0, 0);
    step("after_bubble",   0, 0,  0,  0,  0,  0,  0,  0, 0, ADV,  1, 0, 0);
    step("load_r0",        0, 0,  0,  0,  1,  0,  0,  0, 0, ADV,  1, 0, 0);
    step("miss_c1",        0, 0,  1,  0,  0,  0,  0,  0, 0, FRZ,  1, 0, 0);
    step("miss_c2",        0, 0,  1,  0,  0,  0,  0,  0, 0, FRZ,  2, 1, 0);
    step("miss_c3",        0, 0,  1,  0,  0,  0,  0,  0, 0, FRZ,  3, 1, 0);
    step("miss_c4",        0, 0,  1,  0,  0,  0,  0,  0, 0, FRZ,  4, 1, 0);
    step("miss_ack",       0, 0,  1,  1,  0,  0,  0,  0, 0, ADV,  5, 1, 0);
    step("post_ack",       0, 0,  0,  0,  0,  0,  0,  0, 0, ADV,  5, 1, 0);
    step("prio_freeze",    0, 0,  1,  0,  1,  7,  7,  0, 1, FRZ,  5, 1, 0);
    step("prio_loaduse",   0, 0,  1,  1,  1,  7,  7,  0, 1, LU,   6, 2, 0);
    step("prio_branch",    0, 0,  0,  0,  0,  0,  0,  0, 1, BR,   7, 2, 0);
    step("hit",            0, 0,  1,  1,  0,  0,  0,  0, 0, ADV,  7, 2, 0);
    step("after_hit",      0, 0,  0,  0,  0,  0,  0,  0, 0, ADV,  7, 2, 0);
    step("b2b_miss1",      0, 0,  1,  0,  0,  0,  0,  0, 0, FRZ,  7, 2, 0);
    step("b2b_ack",        0, 0,  1,  1,  0,  0,  0,  0, 0, ADV,  8, 3, 0);
    step("b2b_miss2",      0, 0,  1,  0,  0,  0,  0,  0, 0, FRZ,  8, 3, 0);
    step("req_drop",       0, 0,  0,  0,  0,  0,  0,  0, 0, ADV,  9, 4, 0);
    step("perr_sticky",    0, 0,  0,  0,  0,  0,  0,  0, 0, ADV,  9, 4, 1);
    step("miss_after_err", 0, 0,  1,  0,  0,  0,  0,  0, 0, FRZ,  9, 4, 1);
    step("ack_after_err",  0, 0,  1,  1,  0,  0,  0,  0, 0, ADV, 10, 5, 1);
    step("miss_pre_rst",   0, 0,  1,  0,  0,  0,  0,  0, 0, FRZ, 10, 5, 1);
    step("rst_midcycle",   0, 1,  1,  0,  0,  0,  0,  0, 0, FRZ,  0, 0, 0);
    step("rst_release",    0, 0,  0,  0,  0,  0,  0,  0, 0, ADV,  0, 0, 0);
    step("rst_in_run",     0, 0,  0,  0,  0,  0,  0,  0, 0, ADV,  0, 0, 0);
    step("match_no_load",  0, 0,  0,  0,  0,  5,  5,  0, 0, ADV,  0, 0, 0);
    step("load_use_rs31",  0, 0,  0,  0,  1, 31, 31,  0, 0, LU,   0, 0, 0);
    step("after_rs31",     0, 0,  0,  0,  0,  0,  0,  0, 0, ADV,  1, 0, 0);

    // saturation: 4-bit counters under a long freeze
    for (int k = 0; k < 22; k++)
      step($sformatf("sat_c%0d", k), 1, 0, 1, 0, 0, 0, 0, 0, 0, FRZ,
           (k > 15) ? 15 : k, (k > 0) ? 1 : 0, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Pipeline sequencing controller for the 5-stage CPU with data cache. It decides each cycle whether the pipeline advances, freezes on a dcache miss, inserts a load-use bubble that the forwarding unit cannot cover, or flushes IF/ID on a taken branch. It sits beside the forwarding unit and drives the PC, IF/ID, ID/EX and global freeze enables. It also keeps saturating performance counters for stall and miss cycles.

## Interface
- CNT_W, 32, width of performance counters
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset, asynchronous, active-high
- MemRead_EX_i  input  1  instruction in EX is a load
- Write_Register_EX_i  input  5  destination register of the EX instruction
- Read_Register_1_ID_i  input  5  rs of the ID instruction
- Read_Register_2_ID_i  input  5  rt of the ID instruction
- Branch_Taken_ID_i  input  1  branch resolved taken in ID
- Mem_Req_MEM_i  input  1  MEM-stage instruction accesses the dcache (load or store)
- Dcache_Ack_i  input  1  dcache completes the current MEM access this cycle
- PC_Write_o  output  1  PC register enable
- IF_ID_Write_o  output  1  IF/ID register enable
- IF_ID_Flush_o  output  1  IF/ID loads a NOP
- ID_EX_Flush_o  output  1  ID/EX loads a bubble (all control bits 0)
- Freeze_o  output  1  hold every pipeline register (PC through MEM/WB)
- Stall_Count_o  output  CNT_W  cycles with Freeze_o or a load-use bubble
- Miss_Count_o  output  CNT_W  number of dcache waits entered
- Protocol_Err_o  output  1  sticky: request dropped while waiting

## Operation
- FSM states: RUN, MEM_WAIT.
- miss = Mem_Req_MEM_i & ~Dcache_Ack_i.
- load_use = MemRead_EX_i & (Write_Register_EX_i != 0) & ((Write_Register_EX_i == Read_Register_1_ID_i) | (Write_Register_EX_i == Read_Register_2_ID_i)).
- Output priority is freeze > load-use > branch:
  - Freeze_o = miss, in either state. PC_Write_o = 0 and IF_ID_Write_o = 0. No flush is asserted.
  - Otherwise, if load_use: PC_Write_o = 0, IF_ID_Write_o = 0, ID_EX_Flush_o = 1, IF_ID_Flush_o = 0. A branch in the same cycle is ignored and re-resolves next cycle.
  - Otherwise, if Branch_Taken_ID_i: IF_ID_Flush_o = 1, PC_Write_o = 1, IF_ID_Write_o = 1.
  - Otherwise all enables are 1 and all flushes are 0.
- RUN → MEM_WAIT when miss. Miss_Count_o increments on that edge.
- MEM_WAIT → RUN when Dcache_Ack_i. In the ack cycle Freeze_o = 0 and the pipeline advances on that edge.
- MEM_WAIT with Mem_Req_MEM_i = 0 is a protocol error:
  - Return to RUN.
  - Set Protocol_Err_o. It is cleared only by reset.
  - Outputs that cycle follow the non-freeze rules.
- Stall_Count_o increments on every edge where Freeze_o or (load_use & ~Freeze_o) was 1.
- Both counters saturate at all-ones and never wrap.
- Register comparisons use 5-bit equality. Register 0 never causes a load-use stall.

## Timing
- All outputs except the counters and Protocol_Err_o are combinational from inputs and state, with zero latency.
- Counters and the error flag update on the rising edge.
- Reset, while rst_i is high and asynchronously on assertion:
  - State RUN.
  - Counters 0, Protocol_Err_o 0.
  - Freeze_o = 1, PC_Write_o = 0, IF_ID_Write_o = 0, both flushes 0.
- The first edge after rst_i falls evaluates normally.
- Reset in MEM_WAIT aborts the wait. After release, state is RUN and no miss is counted until a new miss.
- An ack in the same cycle as the request is a hit:
  - No state change, no freeze, no Miss_Count_o increment.
- Ack in MEM_WAIT with a new request already asserted returns to RUN. A new miss the following cycle re-enters MEM_WAIT.
- A load-use stall lasts exactly one cycle: next cycle the load is in MEM and the forwarding unit covers the hazard. If that load then misses, freeze takes over.

## Test plan
- Reset: assert rst_i mid-cycle → Freeze_o = 1 and PC_Write_o = 0 immediately. After release, counters = 0 and state = RUN.
- Load-use: MemRead_EX_i = 1, Write_Register_EX_i = 5, Read_Register_2_ID_i = 5 → one cycle with PC_Write_o = 0, IF_ID_Write_o = 0, ID_EX_Flush_o = 1. Stall_Count_o = 1. Repeat with register 0 → no stall.
- Dcache miss: Mem_Req_MEM_i = 1, Dcache_Ack_i = 0 for 4 cycles, then ack → Freeze_o high for exactly 4 cycles and low in the ack cycle. Miss_Count_o = 1, Stall_Count_o = 4.
- Priority: miss + load-use + Branch_Taken_ID_i together → only Freeze_o = 1, no flushes. After ack, load_use still true → bubble; next cycle branch → IF_ID_Flush_o = 1.
- Hit: request and ack in the same cycle → no freeze, Miss_Count_o unchanged. Back-to-back miss after an ack → Miss_Count_o = 2.
- Protocol error, then saturation:
  - In MEM_WAIT, drop Mem_Req_MEM_i → Protocol_Err_o = 1 and state = RUN.
  - Force CNT_W = 4 and 20 freeze cycles → Stall_Count_o holds at 15.
